aib_axi_follower_mem_responder: RTL

AIB_AXI_FOLLOWER_MEM_RESPONDER -- requirements
Module: aib_axi_follower_mem_responder

---
 rtl/aib_axi_follower_mem_responder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/aib_axi_follower_mem_responder.sv
// AXI follower backed by a 128-bit wide memory array.
// Independent write and read burst engines share one array.
module aib_axi_follower_mem_responder #(
  parameter int IDWIDTH   = 4,
  parameter int ADDRWIDTH = 32,
  parameter int MEM_AW    = 8
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic [IDWIDTH-1:0]   s_axi_awid,
  input  logic [ADDRWIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]           s_axi_awlen,
  input  logic [2:0]           s_axi_awsize,
  input  logic [1:0]           s_axi_awburst,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [IDWIDTH-1:0]   s_axi_wid,
  input  logic [127:0]         s_axi_wdata,
  input  logic [15:0]          s_axi_wstrb,
  input  logic                 s_axi_wlast,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [IDWIDTH-1:0]   s_axi_bid,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [IDWIDTH-1:0]   s_axi_arid,
  input  logic [ADDRWIDTH-1:0] s_axi_araddr,
  input  logic [7:0]           s_axi_arlen,
  input  logic [2:0]           s_axi_arsize,
  input  logic [1:0]           s_axi_arburst,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [IDWIDTH-1:0]   s_axi_rid,
  output logic [127:0]         s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rlast,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_DATA} rdst_t;

  logic [127:0] r_mem [DEPTH];

  wst_t               r_wst;
  logic [IDWIDTH-1:0] r_awid;
  logic [MEM_AW-1:0]  r_widx;
  logic [7:0]         r_wlen;
  logic [7:0]         r_wcnt;
  logic [1:0]         r_wburst;
  logic [1:0]         r_werr;
  logic               r_wlerr;
  logic [1:0]         r_bresp;

  rdst_t              r_rst;
  logic [IDWIDTH-1:0] r_arid;
  logic [MEM_AW-1:0]  r_ridx;
  logic [7:0]         r_rlen;
  logic [7:0]         r_rcnt;
  logic [1:0]         r_rburst;
  logic [1:0]         r_rerr;
  logic [127:0]       r_rdata;
  logic               r_rlast;
  logic               r_rvalid;

  logic [1:0]         w_awerr;
  logic [1:0]         w_arerr;
  logic [MEM_AW-1:0]  w_awidx;
  logic [MEM_AW-1:0]  w_aridx;
  logic [MEM_AW-1:0]  w_wnext;
  logic [MEM_AW-1:0]  w_rnext;
  logic               w_we;
  logic               w_unused;

  assign w_unused = ^{s_axi_wid, s_axi_awaddr[3:0],
                      s_axi_araddr[3:0]};

  // Address-phase error class: out-of-range beats DECERR,
  // unsupported size or reserved burst type SLVERR.
  assign w_awerr =
    (|s_axi_awaddr[ADDRWIDTH-1:MEM_AW+4]) ? DECERR :
    (s_axi_awsize != 3'd4 || s_axi_awburst == 2'b11) ?
      SLVERR : OKAY;
  assign w_arerr =
    (|s_axi_araddr[ADDRWIDTH-1:MEM_AW+4]) ? DECERR :
    (s_axi_arsize != 3'd4 || s_axi_arburst == 2'b11) ?
      SLVERR : OKAY;

  assign w_awidx = s_axi_awaddr[MEM_AW+3:4];
  assign w_aridx = s_axi_araddr[MEM_AW+3:4];

  // FIXED holds the word; INCR and WRAP step modulo DEPTH.
  assign w_wnext = (r_wburst == 2'b00) ? r_widx :
                   r_widx + {{(MEM_AW-1){1'b0}}, 1'b1};
  assign w_rnext = (r_rburst == 2'b00) ? r_ridx :
                   r_ridx + {{(MEM_AW-1){1'b0}}, 1'b1};

  assign w_we = (r_wst == W_DATA) && s_axi_wvalid &&
                (r_werr == OKAY);

  assign s_axi_awready = (r_wst == W_IDLE);
  assign s_axi_wready  = (r_wst == W_DATA);
  assign s_axi_bvalid  = (r_wst == W_RESP);
  assign s_axi_bid     = r_awid;
  assign s_axi_bresp   = r_bresp;

  assign s_axi_arready = (r_rst == R_IDLE);
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rid     = r_arid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rerr;
  assign s_axi_rlast   = r_rlast;

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge clk_wr) begin
    if (w_we) begin
      for (int i = 0; i < 16; i++) begin
        if (s_axi_wstrb[i])
          r_mem[r_widx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // Write burst engine: address, fixed-length data, response.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_wst    <= W_IDLE;
      r_awid   <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wburst <= '0;
      r_werr   <= OKAY;
      r_wlerr  <= 1'b0;
      r_bresp  <= OKAY;
    end else begin
      unique case (r_wst)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            r_awid   <= s_axi_awid;
            r_widx   <= w_awidx;
            r_wlen   <= s_axi_awlen;
            r_wburst <= s_axi_awburst;
            r_werr   <= w_awerr;
            r_wcnt   <= '0;
            r_wlerr  <= 1'b0;
            r_wst    <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            r_widx <= w_wnext;
            r_wcnt <= r_wcnt + 8'd1;
            if (r_wcnt == r_wlen) begin
              r_wst <= W_RESP;
              if (r_werr == DECERR)
                r_bresp <= DECERR;
              else if (r_wlerr || !s_axi_wlast)
                r_bresp <= SLVERR;
              else
                r_bresp <= r_werr;
            end else if (s_axi_wlast) begin
              r_wlerr <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready)
            r_wst <= W_IDLE;
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  // Read burst engine: data registered one cycle after
  // each accepted address or beat, so reads see old data.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_rst    <= R_IDLE;
      r_arid   <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rburst <= '0;
      r_rerr   <= OKAY;
      r_rdata  <= '0;
      r_rlast  <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      unique case (r_rst)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            r_arid   <= s_axi_arid;
            r_ridx   <= w_aridx;
            r_rlen   <= s_axi_arlen;
            r_rburst <= s_axi_arburst;
            r_rerr   <= w_arerr;
            r_rcnt   <= '0;
            r_rdata  <= (w_arerr != OKAY) ? '0 : r_mem[w_aridx];
            r_rlast  <= (s_axi_arlen == 8'd0);
            r_rvalid <= 1'b1;
            r_rst    <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rst    <= R_IDLE;
            end else begin
              r_ridx  <= w_rnext;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rdata <= (r_rerr != OKAY) ? '0 : r_mem[w_rnext];
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

endmodule
